// File: rtl/mult4_seq_ctrl.sv
// Sequential 4x4 -> 8-bit multiplier controller driving one shared 2x2 core over four passes.
// Optional: MULT4_SEQ_ZERO_SKIP_EN sends zero-operand requests straight to DONE.
module mult4_seq_ctrl #(
    parameter bit IDLE_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_p,
    output logic       busy,
    output logic       mul_en,
    output logic [1:0] mul_a,
    output logic [1:0] mul_b,
    input  logic [3:0] mul_p
);

    typedef enum logic [2:0] {
        StIdle,
        StLl,
        StLh,
        StHl,
        StHh,
        StDone
    } state_e;

    state_e     state_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [7:0] acc_q;
    logic [1:0] hold_a_q;
    logic [1:0] hold_b_q;

    logic [1:0] pass_a;
    logic [1:0] pass_b;
    logic [2:0] shift;
    logic [7:0] pp;

    always_comb begin
        pass_a = 2'b00;
        pass_b = 2'b00;
        shift  = 3'd0;
        mul_en = 1'b0;
        case (state_q)
            StLl: begin
                pass_a = a_q[1:0];
                pass_b = b_q[1:0];
                shift  = 3'd0;
                mul_en = 1'b1;
            end
            StLh: begin
                pass_a = a_q[1:0];
                pass_b = b_q[3:2];
                shift  = 3'd2;
                mul_en = 1'b1;
            end
            StHl: begin
                pass_a = a_q[3:2];
                pass_b = b_q[1:0];
                shift  = 3'd2;
                mul_en = 1'b1;
            end
            StHh: begin
                pass_a = a_q[3:2];
                pass_b = b_q[3:2];
                shift  = 3'd4;
                mul_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        pp = {4'b0000, mul_p} << shift;
    end

    // Outside passes the core inputs are either parked at zero or hold the last pass value.
    always_comb begin
        if (mul_en) begin
            mul_a = pass_a;
            mul_b = pass_b;
        end else if (IDLE_ZERO) begin
            mul_a = 2'b00;
            mul_b = 2'b00;
        end else begin
            mul_a = hold_a_q;
            mul_b = hold_b_q;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        out_p     = acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            acc_q    <= 8'd0;
            hold_a_q <= 2'b00;
            hold_b_q <= 2'b00;
        end else begin
            if (mul_en) begin
                acc_q    <= acc_q + pp;
                hold_a_q <= pass_a;
                hold_b_q <= pass_b;
            end
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        acc_q <= 8'd0;
`ifdef MULT4_SEQ_ZERO_SKIP_EN
                        if ((in_a == 4'd0) || (in_b == 4'd0)) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StLl;
                        end
`else
                        state_q <= StLl;
`endif
                    end
                end
                StLl: state_q <= StLh;
                StLh: state_q <= StHl;
                StHl: state_q <= StHh;
                StHh: state_q <= StDone;
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
